nibble_pair_rx: RTL and testbench

Receive-side counterpart of the nibble inverter stage: accepts active-low (inverted) 4-bit nibbles qualified by a strobe, restores true polarity, and assembles each pair of nibbles into one byte. It presents each byte through a single-entry valid/ready holding register. It also flags overruns and abandoned half-frames (timeout). It sits between the pad-level nibble bus and any byte-wide consumer in the tile.

---
 rtl/nibble_pair_rx.sv | 152 +++++++++++++++
 tb/tb_nibble_pair_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_pair_rx.sv
// Receiver for active-low nibble pairs: restores polarity, assembles bytes and holds them in a one-entry valid/ready register.
// Define NIBBLE_RX_SYNC_EN to add a 2-flop input synchronizer on stb/nib_n ahead of the edge detector.
module nibble_pair_rx #(
    parameter int HI_FIRST = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] nib_n,
    input  logic       stb,
    input  logic       byte_ready,
    input  logic       clear_ovr,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE,
        HAVE_FIRST
    } state_t;

    state_t      state_q, state_d;
    logic        stb_s;
    logic [3:0]  nib_s;
    logic        stb_prev_q;
    logic        stb_edge;
    logic [3:0]  nib_true;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic        tmo_hit;
    logic        first_ld, complete, timeout;
    logic [3:0]  first_q, first_d;
    logic [7:0]  assembled;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;
    logic        ferr_q, ferr_d;
    logic        load, drop;

`ifdef NIBBLE_RX_SYNC_EN
    logic [1:0] stb_sync_q;
    logic [3:0] nib_s1_q, nib_s2_q;

    // stb stages reset high so a strobe already high at release is not seen as an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb_sync_q <= '1;
            nib_s1_q   <= '0;
            nib_s2_q   <= '0;
        end else begin
            stb_sync_q <= {stb_sync_q[0], stb};
            nib_s1_q   <= nib_n;
            nib_s2_q   <= nib_s1_q;
        end
    end

    assign stb_s = stb_sync_q[1];
    assign nib_s = nib_s2_q;
`else
    assign stb_s = stb;
    assign nib_s = nib_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stb_prev_q <= 1'b1;
        else     stb_prev_q <= stb_s;
    end

    assign stb_edge = stb_s & ~stb_prev_q;
    assign nib_true = ~nib_s;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign tmo_hit  = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (stb_edge) state_d = HAVE_FIRST;
            HAVE_FIRST: if (stb_edge || tmo_hit) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == HAVE_FIRST);
        first_ld = (state_q == IDLE) && stb_edge;
        complete = (state_q == HAVE_FIRST) && stb_edge;
        timeout  = (state_q == HAVE_FIRST) && !stb_edge && tmo_hit;
    end

    assign assembled = (HI_FIRST != 0) ? {first_q, nib_true} : {nib_true, first_q};
    assign load      = complete && (!valid_q || byte_ready);
    assign drop      = complete && valid_q && !byte_ready;

    always_comb begin
        cnt_d   = cnt_q;
        first_d = first_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        ferr_d  = timeout;

        if (first_ld)                 cnt_d = '0;
        else if (busy && !stb_edge)   cnt_d = cnt_inc;

        if (first_ld)     first_d = nib_true;
        else if (timeout) first_d = '0;

        // a load in the accept cycle replaces the consumed byte, keeping valid high
        if (load) begin
            byte_d  = assembled;
            valid_d = 1'b1;
        end else if (valid_q && byte_ready) begin
            valid_d = 1'b0;
        end

        if (drop)           ovr_d = 1'b1;
        else if (clear_ovr) ovr_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            first_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            first_q <= first_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = valid_q;
    assign overrun    = ovr_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_nibble_pair_rx.sv
// Directed scoreboard bench for nibble_pair_rx: one HI_FIRST=1/TIMEOUT=16 instance and one HI_FIRST=0/TIMEOUT=0 instance.
module tb_nibble_pair_rx;

`ifdef NIBBLE_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] nib_n;
    logic       stb;
    logic       byte_ready;
    logic       clear_ovr;
    logic [7:0] a_byte, b_byte;
    logic       a_valid, b_valid;
    logic       a_ovr, b_ovr;
    logic       a_ferr, b_ferr;
    logic       a_busy, b_busy;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    logic [7:0]  exp_q[$];

    nibble_pair_rx #(.HI_FIRST(1), .TIMEOUT(16)) dut_a (
        .clk(clk), .rst(rst), .nib_n(nib_n), .stb(stb),
        .byte_ready(byte_ready), .clear_ovr(clear_ovr),
        .byte_out(a_byte), .byte_valid(a_valid), .overrun(a_ovr),
        .frame_err(a_ferr), .busy(a_busy)
    );

    nibble_pair_rx #(.HI_FIRST(0), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .nib_n(nib_n), .stb(stb),
        .byte_ready(byte_ready), .clear_ovr(clear_ovr),
        .byte_out(b_byte), .byte_valid(b_valid), .overrun(b_ovr),
        .frame_err(b_ferr), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $error("FAIL %s: observed %0h expected <no byte queued>", tag, a_byte);
        end else begin
            chk(tag, a_byte, exp_q[0]);
        end
    endtask

    task automatic sb_pop();
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    // called just after a negedge; returns at the negedge following the capture edge, stb still high
    task automatic send(input logic [3:0] n);
        nib_n = n;
        stb   = 1'b1;
        repeat (LAT + 1) @(negedge clk);
    endtask

    task automatic gap(input int unsigned k);
        stb = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; nib_n = 4'hF; byte_ready = 1'b0; clear_ovr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_byte",  a_byte,  8'h00);
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_ovr",   a_ovr,   1'b0);
        chk("rst_ferr",  a_ferr,  1'b0);
        chk("rst_busy",  a_busy,  1'b0);
        rst = 1'b0;
        gap(2);

        // basic pair, consumer always ready
        byte_ready = 1'b1;
        send(4'hC);
        chk("t1_busy_first", a_busy, 1'b1);
        chk("t1_valid_first", a_valid, 1'b0);
        gap(2);
        chk("t1_busy_gap", a_busy, 1'b1);
        exp_q.push_back(8'h35);
        send(4'hA);
        sb_check("t1_byte");
        chk("t1_valid", a_valid, 1'b1);
        chk("t1_busy_done", a_busy, 1'b0);
        sb_pop();
        gap(1);
        chk("t1_valid_1cyc", a_valid, 1'b0);
        chk("t1_byte_kept", a_byte, 8'h35);
        gap(1);

        // low-first assembly with a stalled consumer
        byte_ready = 1'b0;
        send(4'hC);
        gap(2);
        exp_q.push_back(8'h35);
        send(4'hA);
        chk("t2_b_byte", b_byte, 8'h53);
        chk("t2_b_valid", b_valid, 1'b1);
        sb_check("t2_a_byte");
        gap(4);
        chk("t2_b_valid_hold", b_valid, 1'b1);
        chk("t2_b_byte_hold", b_byte, 8'h53);
        chk("t2_b_ovr", b_ovr, 1'b0);
        byte_ready = 1'b1;
        @(negedge clk);
        byte_ready = 1'b0;
        chk("t2_b_valid_clr", b_valid, 1'b0);
        chk("t2_a_valid_clr", a_valid, 1'b0);
        sb_pop();
        gap(1);

        // overrun: second byte dropped, first kept
        exp_q.push_back(8'h35);
        send(4'hC); gap(2); send(4'hA); gap(2);
        send(4'hE); gap(2); send(4'hD);
        sb_check("t3_byte_kept");
        chk("t3_valid", a_valid, 1'b1);
        chk("t3_ovr_set", a_ovr, 1'b1);
        gap(1);
        clear_ovr = 1'b1;
        @(negedge clk);
        clear_ovr = 1'b0;
        chk("t3_ovr_clr", a_ovr, 1'b0);
        sb_check("t3_byte_after_clr");
        gap(1);

        // accept of 0x35 and load of 0xF0 in the same edge
        send(4'h0);
        gap(2);
        sb_pop();
        exp_q.push_back(8'hF0);
        nib_n = 4'hF;
        stb   = 1'b1;
        repeat (LAT) @(negedge clk);
        byte_ready = 1'b1;
        @(negedge clk);
        byte_ready = 1'b0;
        sb_check("t4_byte");
        chk("t4_valid", a_valid, 1'b1);
        chk("t4_ovr", a_ovr, 1'b0);
        stb = 1'b0;
        byte_ready = 1'b1;
        @(negedge clk);
        byte_ready = 1'b0;
        sb_pop();
        chk("t4_valid_clr", a_valid, 1'b0);
        gap(2);

        // timeout after 16 idle cycles
        send(4'hC);
        gap(15);
        chk("t5_ferr_early", a_ferr, 1'b0);
        chk("t5_busy_early", a_busy, 1'b1);
        @(negedge clk);
        chk("t5_ferr_pulse", a_ferr, 1'b1);
        chk("t5_busy_clr", a_busy, 1'b0);
        chk("t5_b_no_tmo_busy", b_busy, 1'b1);
        chk("t5_b_no_tmo_ferr", b_ferr, 1'b0);
        @(negedge clk);
        chk("t5_ferr_end", a_ferr, 1'b0);
        gap(2);
        exp_q.push_back(8'h35);
        send(4'hC); gap(2); send(4'hA);
        sb_check("t5_after_tmo_byte");
        chk("t5_after_tmo_valid", a_valid, 1'b1);
        stb = 1'b0;
        byte_ready = 1'b1;
        @(negedge clk);
        byte_ready = 1'b0;
        sb_pop();
        gap(2);

        // second nibble lands exactly when the count reaches 16
        send(4'h3);
        gap(15 - LAT);
        exp_q.push_back(8'hC3);
        send(4'hC);
        sb_check("t6_tie_byte");
        chk("t6_tie_valid", a_valid, 1'b1);
        chk("t6_tie_ferr", a_ferr, 1'b0);
        chk("t6_tie_busy", a_busy, 1'b0);
        gap(1);
        chk("t6_tie_ferr_late", a_ferr, 1'b0);
        gap(1);

        // asynchronous reset while busy and holding a byte
        send(4'hC);
        chk("t7_pre_busy", a_busy, 1'b1);
        chk("t7_pre_valid", a_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t7_rst_byte",  a_byte,  8'h00);
        chk("t7_rst_valid", a_valid, 1'b0);
        chk("t7_rst_ovr",   a_ovr,   1'b0);
        chk("t7_rst_ferr",  a_ferr,  1'b0);
        chk("t7_rst_busy",  a_busy,  1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t7_no_capture_busy", a_busy, 1'b0);
        chk("t7_no_capture_valid", a_valid, 1'b0);
        gap(2);
        send(4'hC);
        chk("t7_capture_resumes", a_busy, 1'b1);
        gap(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
